shift_seq: RTL
==============

# shift_seq

Multi-cycle shift sequencer for the ALU shift path. It accepts one shift request at a time: SLL, SRL or SRA of a 32-bit operand by a 5-bit amount. It realizes the shift by applying one power-of-two stage (16, 8, 4, 2, 1) per clock, only for the set bits of the amount. Latency therefore equals the popcount of the shift amount. It sits between the processor's execute-stage issue logic and the writeback mux, and uses a valid/ready handshake on both sides.

## Interface
- No parameters; width fixed at 32 bits, shift amount fixed at 5 bits.
- clock  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request valid; accepted only when ready=1.
- op  input  2  00 SLL, 01 SRL, 10 SRA, 11 treated as SLL.
- data_in  input  32  operand; sampled on the accept edge.
- shamt  input  5  shift amount; sampled on the accept edge.
- flush  input  1  synchronous abort; returns to IDLE on the next edge.
- result_ready  input  1  consumer accepts result.
- ready  output  1  high only in IDLE.
- busy  output  1  equals ~ready.
- result  output  32  shifted value; registered.
- result_valid  output  1  high only in DONE.

## Operation
- State machine has three states: IDLE, SHIFT, DONE.
- Internal registers:
  - acc[31:0], the working value.
  - rem[4:0], the remaining shift amount.
  - op_q[1:0], the latched operation.
  - sign_q, equal to data_in[31] captured at accept.
- IDLE:
  - ready=1.
  - On start=1, accept: acc<=data_in, rem<=shamt, op_q<=op, sign_q<=data_in[31].
  - If shamt==0, go to DONE with result<=data_in. Otherwise go to SHIFT.
  - start=0 stays in IDLE.
- SHIFT, each edge:
  - Select the highest set bit of rem, giving stage s in {16,8,4,2,1}.
  - Update acc<=stage_s(acc), then clear that bit of rem.
  - If the cleared rem is 0, load result with the new acc and go to DONE.
- Stage fill rules:
  - SLL: vacated low bits filled with 0.
  - SRL: vacated high bits filled with 0.
  - SRA: vacated high bits filled with sign_q.
  - Composition of stages equals the single shift by shamt for all three ops.
- DONE:
  - result_valid=1; result holds stable.
  - On result_ready=1, go to IDLE.
  - result keeps its value after leaving DONE, until the next completion.
- start while not in IDLE is ignored and not queued.
- flush=1 in any state:
  - Next state is IDLE; rem is cleared.
  - result is unchanged and result_valid drops.
  - flush has priority over start, stepping and result_ready in the same cycle.
- Reset (asynchronous, reset=0), at any time including mid-shift:
  - State becomes IDLE.
  - acc, rem, op_q, sign_q and result are all 0.
  - result_valid=0, ready=1, busy=0.

## Timing
- Define k = popcount(shamt), with 0 ≤ k ≤ 5. Call the accept edge E.
- result_valid rises after edge E+k.
  - k=0: DONE is entered on E itself.
  - k=5 (e.g. shamt=31): 5 SHIFT cycles.
- Each request occupies DONE for at least one cycle.
- Back-to-back throughput, with result_ready held high, is one request per k+2 cycles:
  - accept edge;
  - k stepping edges;
  - the DONE→IDLE edge.
- ready is a combinational decode of state; no combinational path from start to ready.
- result and result_valid are registered or state-decoded; no combinational path from inputs.
- Simultaneous start and result_ready in DONE: start is ignored. A new request is accepted only in IDLE.

## Test plan
- Reset values: hold reset=0 for 2 cycles, then release.
  - Required: ready=1, busy=0, result_valid=0, result=0x00000000.
- SLL, k=1: op=00, data_in=0x000000FF, shamt=8.
  - Required: result_valid rises 1 cycle after accept, result=0x0000FF00.
  - With result_ready=1, ready returns 1 cycle later.
- SRA and SRL, k=5, shamt=31, data_in=0x80000000.
  - SRA (op=10): result=0xFFFFFFFF after 5 cycles.
  - SRL (op=01): result=0x00000001 after 5 cycles.
  - Also SRA of 0x7FFFFFF0 by 4: result=0x07FFFFFF after 1 cycle.
- Zero shift and backpressure: op=00, data_in=0xDEADBEEF, shamt=0, result_ready held 0 for 3 cycles.
  - Required: result_valid=1 in the cycle after accept, held with result=0xDEADBEEF for all 3 cycles.
  - A start pulse presented during those cycles is not accepted.
  - Required: IDLE only after result_ready=1.
- Flush mid-operation: SLL 0x1 by shamt=21 (k=3), assert flush on the 2nd SHIFT cycle.
  - Required: IDLE next edge, result_valid never asserted, result unchanged from its prior value.
  - A subsequent request completes normally.
- Async reset mid-operation: assert reset=0 between clock edges during SHIFT.
  - Required: outputs take their reset values immediately, without a clock edge.
  - After release, the first start is accepted correctly.

Source files
------------

// File: rtl/shift_seq_if.sv
// Request/result handshake bundle for the shift sequencer.
// master: execute-stage issue logic and writeback consumer.
// slave:  the shift sequencer itself.
interface shift_seq_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic        flush;
    logic        result_ready;
    logic        ready;
    logic        busy;
    logic [31:0] result;
    logic        result_valid;

    modport master (
        output start, op, data_in, shamt, flush, result_ready,
        input  ready, busy, result, result_valid
    );

    modport slave (
        input  start, op, data_in, shamt, flush, result_ready,
        output ready, busy, result, result_valid
    );
endinterface

// File: rtl/shift_seq.sv
// Multi-cycle shift sequencer: SLL/SRL/SRA of a 32-bit operand, one
// power-of-two stage (16,8,4,2,1) per clock for each set bit of the amount.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a request; start samples operand, op and amount
// SHIFT | applying the highest remaining power-of-two stage per edge
// DONE  | result_valid high, waiting for result_ready
module shift_seq (
    input  logic        clock,
    input  logic        reset,
    shift_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] acc;
    logic [4:0]  rem;
    logic [1:0]  op_q;
    logic        sign_q;
    logic [31:0] result_q;

    // Stage select: the one-hot of rem's highest set bit is also the
    // numeric shift amount of that stage (16, 8, 4, 2 or 1).
    logic [4:0]  stage;
    logic [4:0]  rem_next;
    logic [31:0] acc_next;

    // Pick the highest set bit of rem and apply that stage to acc.
    always_comb begin
        stage    = 5'b00000;
        rem_next = rem;
        acc_next = acc;
        if (rem[4])      stage = 5'b10000;
        else if (rem[3]) stage = 5'b01000;
        else if (rem[2]) stage = 5'b00100;
        else if (rem[1]) stage = 5'b00010;
        else if (rem[0]) stage = 5'b00001;
        rem_next = rem & ~stage;
        case (op_q)
            2'b01:   acc_next = acc >> stage;
            2'b10:   acc_next = (acc >> stage) |
                                ({32{sign_q}} & ~(32'hFFFF_FFFF >> stage));
            default: acc_next = acc << stage;
        endcase
    end

    // Sequencer state, working registers and the registered result.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            acc      <= 32'd0;
            rem      <= 5'd0;
            op_q     <= 2'b00;
            sign_q   <= 1'b0;
            result_q <= 32'd0;
        end else if (bus.flush) begin
            // Abort wins over everything else; result keeps its last value.
            state <= IDLE;
            rem   <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc    <= bus.data_in;
                        rem    <= bus.shamt;
                        op_q   <= bus.op;
                        sign_q <= bus.data_in[31];
                        if (bus.shamt == 5'd0) begin
                            result_q <= bus.data_in;
                            state    <= DONE;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    acc <= acc_next;
                    rem <= rem_next;
                    if (rem_next == 5'd0) begin
                        result_q <= acc_next;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    // start here is deliberately ignored, never queued.
                    if (bus.result_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake outputs are pure state decodes; no input-to-output path.
    assign bus.ready        = (state == IDLE);
    assign bus.busy         = (state != IDLE);
    assign bus.result_valid = (state == DONE);
    assign bus.result       = result_q;

endmodule
